// File: rtl/meas_pkg.sv
// Shared encodings for the frequency measurement sequencer: FSM states and
// result byte-select codes.
package meas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [1:0] BYTE_LSB  = 2'd0;
    localparam logic [1:0] BYTE_MID  = 2'd1;
    localparam logic [1:0] BYTE_MSB  = 2'd2;
    localparam logic [1:0] BYTE_STAT = 2'd3;

endpackage

// File: rtl/sat_edge_counter.sv
// Saturating edge counter: clears on clr, counts inc pulses while en is high,
// and parks at all-ones with a sticky sat flag instead of wrapping.
module sat_edge_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en && inc) begin
            if (count == {CNT_W{1'b1}}) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/measure_sequencer.sv
// One-shot oscillator frequency measurement: ARM clears the counter, GATE counts
// edges for N clk cycles, LATCH moves the count into the held result.
module measure_sequencer
    import meas_pkg::*;
#(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_edge,
    input  logic [1:0]        byte_sel,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  result,
    output logic [7:0]        out_byte
);

    state_t              state_reg, state_next;
    logic [GATE_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]    result_reg;
    logic                overflow_reg;
    logic                done_reg;
    logic                cnt_clr, cnt_en, latch_en;
    logic [CNT_W-1:0]    count;
    logic                sat;
    logic [23:0]         res_ext;

    sat_edge_counter #(.CNT_W(CNT_W)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .inc   (osc_edge),
        .count (count),
        .sat   (sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        latch_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    timer_next = gate_cycles;
                    state_next = ARM;
                end
            end
            ARM: begin
                cnt_clr    = 1'b1;
                state_next = (timer_reg == '0) ? LATCH : GATE;
            end
            GATE: begin
                cnt_en     = 1'b1;
                timer_next = timer_reg - 1'b1;
                if (timer_reg <= GATE_W'(1)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                latch_en   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // abort wins over everything, including the LATCH update
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            latch_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= latch_en;
            if (latch_en) begin
                result_reg   <= count;
                overflow_reg <= sat;
            end
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign result   = result_reg;

    always_comb begin
        res_ext = 24'(result_reg);
        case (byte_sel)
            BYTE_LSB:  out_byte = res_ext[7:0];
            BYTE_MID:  out_byte = res_ext[15:8];
            BYTE_MSB:  out_byte = res_ext[23:16];
            default:   out_byte = {overflow_reg, 7'b0};
        endcase
    end

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer: a default 24-bit instance and a 4-bit
// instance share all inputs so saturation can be exercised alongside.
module tb_measure_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] gate_cycles;
    logic        osc_edge;
    logic [1:0]  byte_sel;

    logic        busy, done, overflow;
    logic [23:0] result;
    logic [7:0]  out_byte;

    logic        busy4, done4, overflow4;
    logic [3:0]  result4;
    logic [7:0]  out_byte4;

    int checks = 0;
    int errors = 0;

    measure_sequencer #(.GATE_W(16), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .osc_edge(osc_edge), .byte_sel(byte_sel),
        .busy(busy), .done(done), .overflow(overflow), .result(result),
        .out_byte(out_byte)
    );

    measure_sequencer #(.GATE_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .osc_edge(osc_edge), .byte_sel(byte_sel),
        .busy(busy4), .done(done4), .overflow(overflow4), .result(result4),
        .out_byte(out_byte4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one measurement starting in the current cycle (cycle 0) and returns
    // in cycle n+3 with done checked high. Edges in window cycles 2..n+1 at the
    // given period; osc_all holds osc_edge high in every cycle instead.
    task automatic do_meas(input int n, input int period, input bit osc_all);
        start       = 1'b1;
        gate_cycles = 16'(n);
        osc_edge    = osc_all;
        check("idle_before_start", {31'b0, busy}, 32'd0);
        tick();
        for (int c = 1; c <= n + 2; c++) begin
            start    = 1'b0;
            osc_edge = osc_all || (period > 0 && c >= 2 && c <= n + 1 && ((c - 2) % period) == 0);
            check("busy_in_run", {31'b0, busy}, 32'd1);
            check("no_early_done", {31'b0, done}, 32'd0);
            tick();
        end
        osc_edge = 1'b0;
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_after_latch", {31'b0, busy}, 32'd0);
        $display("measurement N=%0d period=%0d: result=%0d overflow=%0b", n, period, result, overflow);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        gate_cycles = '0;
        osc_edge    = 1'b0;
        byte_sel    = 2'd0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_result", {8'b0, result}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: N=10, osc high from cycle 0; cycles 0-1 must not count
        do_meas(10, 1, 1'b1);
        check("t1_result", {8'b0, result}, 32'd10);
        check("t1_overflow", {31'b0, overflow}, 32'd0);
        tick();
        check("t1_done_single", {31'b0, done}, 32'd0);

        // 2: N=100, one edge every 4th cycle -> 25
        do_meas(100, 4, 1'b0);
        check("t2_result", {8'b0, result}, 32'd25);
        check("t2_overflow", {31'b0, overflow}, 32'd0);
        byte_sel = 2'd0; #1 check("t2_byte0", {24'b0, out_byte}, 32'h19);
        byte_sel = 2'd1; #1 check("t2_byte1", {24'b0, out_byte}, 32'h00);
        byte_sel = 2'd2; #1 check("t2_byte2", {24'b0, out_byte}, 32'h00);
        byte_sel = 2'd3; #1 check("t2_byte3", {24'b0, out_byte}, 32'h00);
        byte_sel = 2'd0;
        tick();

        // 3: 20 edges saturate the 4-bit instance
        do_meas(20, 1, 1'b1);
        check("t3_result4", {28'b0, result4}, 32'd15);
        check("t3_overflow4", {31'b0, overflow4}, 32'd1);
        check("t3_result24", {8'b0, result}, 32'd20);
        byte_sel = 2'd3; #1 check("t3_byte3_4bit", {24'b0, out_byte4}, 32'h80);
        byte_sel = 2'd0; #1 check("t3_byte0_4bit", {24'b0, out_byte4}, 32'h0F);
        tick();

        // 4: N=0 still pulses done, then back-to-back N=5
        do_meas(0, 1, 1'b1);
        check("t4_result_n0", {8'b0, result}, 32'd0);
        check("t4_overflow4_n0", {31'b0, overflow4}, 32'd0);
        do_meas(5, 1, 1'b0);
        check("t4_result_b2b", {8'b0, result}, 32'd5);
        tick();

        // 5: abort mid-window keeps result 7; stray starts ignored
        do_meas(7, 1, 1'b0);
        check("t5_result_seed", {8'b0, result}, 32'd7);
        tick();
        start       = 1'b1;
        gate_cycles = 16'd50;
        osc_edge    = 1'b1;
        tick();
        for (int c = 1; c <= 19; c++) begin
            start       = (c == 5 || c == 10);
            gate_cycles = (c == 5 || c == 10) ? 16'd3 : 16'd50;
            check("t5_busy", {31'b0, busy}, 32'd1);
            check("t5_no_done", {31'b0, done}, 32'd0);
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        check("t5_busy_at_abort", {31'b0, busy}, 32'd1);
        tick();
        abort = 1'b0;
        check("t5_idle_after_abort", {31'b0, busy}, 32'd0);
        check("t5_no_done_abort", {31'b0, done}, 32'd0);
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_idle", {31'b0, busy}, 32'd0);
        for (int c = 0; c < 60; c++) begin
            check("t5_quiet_done", {31'b0, done}, 32'd0);
            tick();
        end
        check("t5_result_kept", {8'b0, result}, 32'd7);
        $display("abort run: result=%0d busy=%0b", result, busy);

        // 6: asynchronous reset mid-GATE
        start       = 1'b1;
        gate_cycles = 16'd50;
        osc_edge    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("t6_busy_pre", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd0);
        check("t6_result", {8'b0, result}, 32'd0);
        check("t6_out_byte", {24'b0, out_byte}, 32'd0);
        check("t6_result4", {28'b0, result4}, 32'd0);
        $display("async reset: busy=%0b result=%0d", busy, result);
        tick();
        rst      = 1'b0;
        osc_edge = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
